// File: rtl/irq_pipe_ctrl_pkg.sv
// Shared definitions for the interrupt / pipeline-stall controller:
// FSM state encoding and default latencies.
package irq_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TAKE = 2'd2
  } irq_state_t;

  localparam int DEF_N_IRQ   = 6;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/irq_pipe_ctrl_if.sv
// Pipeline-control bundle between ID-stage decode/CP0 and the interrupt/stall controller.
interface irq_pipe_ctrl_if
  import irq_pipe_ctrl_pkg::*;
#(
  parameter int N_IRQ = DEF_N_IRQ
);
  logic [N_IRQ-1:0] irq_req;
  logic [N_IRQ-1:0] irq_mask;
  logic             exl;
  logic             hazard_stall;
  logic             fifo_full;
  logic             id_ctrl_xfer;
  logic             id_eret;
  logic             id_md_mul;
  logic             id_md_div;
  logic             id_md_use;

  logic             pc_write;
  logic             if_flush;
  logic             id_flush;
  logic             exl_set;
  logic             exl_clr;
  logic             npc_from_epc;
  logic [N_IRQ-1:0] irq_cause;
  logic             md_busy;
  logic             md_done;

  modport slave (
    input  irq_req, irq_mask, exl, hazard_stall, fifo_full,
           id_ctrl_xfer, id_eret, id_md_mul, id_md_div, id_md_use,
    output pc_write, if_flush, id_flush, exl_set, exl_clr,
           npc_from_epc, irq_cause, md_busy, md_done
  );

  modport master (
    output irq_req, irq_mask, exl, hazard_stall, fifo_full,
           id_ctrl_xfer, id_eret, id_md_mul, id_md_div, id_md_use,
    input  pc_write, if_flush, id_flush, exl_set, exl_clr,
           npc_from_epc, irq_cause, md_busy, md_done
  );
endinterface

// File: rtl/md_latency_cnt.sv
// Multiply/divide latency tracker: down-counter loaded on issue, busy while
// nonzero, one-cycle registered done pulse once the result is ready.
module md_latency_cnt
  import irq_pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_mul,
  input  logic issue_div,
  output logic md_busy,
  output logic md_done
);
  localparam int CW = $clog2(lat_max(MUL_LAT, DIV_LAT) + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] load_val;
  logic          issue;
  logic          done_q;

  assign issue    = issue_mul | issue_div;
  assign load_val = issue_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

  // Issue is only possible while idle (the top stalls MD ops when busy),
  // so a load never lands mid-count. A zero load is a latency-1 op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (cnt == CW'(1)) || (issue && (load_val == '0));
      if (issue)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  assign md_busy = (cnt != '0);
  assign md_done = done_q;

endmodule

// File: rtl/irq_pipe_ctrl.sv
// Interrupt take/eret sequencing and pipeline stall/flush control for a
// 5-stage MIPS-style core, including multiply/divide occupancy stalls.
module irq_pipe_ctrl
  import irq_pipe_ctrl_pkg::*;
#(
  parameter int N_IRQ   = DEF_N_IRQ,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  irq_pipe_ctrl_if.slave  bus
);
  irq_state_t       state;
  logic [N_IRQ-1:0] cause_q;
  logic             exl_set_q;
  logic             if_flush_q;
  logic             pend;
  logic             md_busy;
  logic             md_stall;
  logic             stall;
  logic             pc_write;

  assign pend     = (|(bus.irq_req & bus.irq_mask)) & ~bus.exl;
  assign md_stall = md_busy & (bus.id_md_mul | bus.id_md_div | bus.id_md_use);
  assign stall    = bus.hazard_stall | md_stall;
  assign pc_write = ~stall & ~bus.fifo_full;

  md_latency_cnt #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_cnt (
    .clk       (clk),
    .reset     (reset),
    .issue_mul (pc_write & bus.id_md_mul),
    .issue_div (pc_write & bus.id_md_div),
    .md_busy   (md_busy),
    .md_done   (bus.md_done)
  );

  // Take only when ID holds neither a control transfer (EPC would point into
  // a delay slot) nor an eret; otherwise the interrupt waits in PEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cause_q    <= '0;
      exl_set_q  <= 1'b0;
      if_flush_q <= 1'b0;
    end else begin
      exl_set_q  <= 1'b0;
      if_flush_q <= 1'b0;
      case (state)
        IDLE: if (pend) state <= PEND;
        PEND: begin
          if (!pend)
            state <= IDLE;
          else if (pc_write && !bus.id_ctrl_xfer && !bus.id_eret) begin
            state      <= TAKE;
            cause_q    <= bus.irq_req & bus.irq_mask;
            exl_set_q  <= 1'b1;
            if_flush_q <= 1'b1;
          end
        end
        TAKE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.id_flush     = stall;
  assign bus.if_flush     = if_flush_q;
  assign bus.exl_set      = exl_set_q;
  assign bus.exl_clr      = bus.id_eret & pc_write & (state != TAKE);
  assign bus.npc_from_epc = bus.id_eret & pc_write & (state != TAKE);
  assign bus.irq_cause    = cause_q;
  assign bus.md_busy      = md_busy;

endmodule

// File: tb/tb_irq_pipe_ctrl.sv
// Self-checking bench for irq_pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-indexed reference model.
module tb_irq_pipe_ctrl;
  localparam int NI  = 6;
  localparam int MUL = 5;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  irq_pipe_ctrl_if #(.N_IRQ(NI)) bus ();

  irq_pipe_ctrl #(.N_IRQ(NI), .MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: interrupt phase (0 waiting-free, 1 pending, 2 taking),
  // last taken cause, and MD op expressed as absolute cycle numbers.
  int            cyc        = 0;
  int            m_phase    = 0;
  logic [NI-1:0] m_cause    = '0;
  int            busy_until = -1;
  int            done_at    = -1;

  always @(negedge clk) begin
    logic e_busy, e_done, e_pend, e_stall, e_pcw, e_eret;
    int   lat;
    if (!reset) begin
      m_phase = 0; m_cause = '0; busy_until = -1; done_at = -1;
    end
    e_busy  = (cyc <= busy_until);
    e_done  = (cyc == done_at);
    e_pend  = (|(bus.irq_req & bus.irq_mask)) && !bus.exl;
    e_stall = bus.hazard_stall || (e_busy && (bus.id_md_mul || bus.id_md_div || bus.id_md_use));
    e_pcw   = !e_stall && !bus.fifo_full;
    e_eret  = bus.id_eret && e_pcw && (m_phase != 2);
    chk("pc_write",     32'(bus.pc_write),     32'(e_pcw));
    chk("id_flush",     32'(bus.id_flush),     32'(e_stall));
    chk("if_flush",     32'(bus.if_flush),     32'(m_phase == 2));
    chk("exl_set",      32'(bus.exl_set),      32'(m_phase == 2));
    chk("exl_clr",      32'(bus.exl_clr),      32'(e_eret));
    chk("npc_from_epc", 32'(bus.npc_from_epc), 32'(e_eret));
    chk("irq_cause",    32'(bus.irq_cause),    32'(m_cause));
    chk("md_busy",      32'(bus.md_busy),      32'(e_busy));
    chk("md_done",      32'(bus.md_done),      32'(e_done));
    if (reset) begin
      case (m_phase)
        0: if (e_pend) m_phase = 1;
        1: if (!e_pend) m_phase = 0;
           else if (e_pcw && !bus.id_ctrl_xfer && !bus.id_eret) begin
             m_phase = 2;
             m_cause = bus.irq_req & bus.irq_mask;
           end
        default: m_phase = 0;
      endcase
      if (e_pcw && (bus.id_md_mul || bus.id_md_div)) begin
        lat        = bus.id_md_div ? DIV : MUL;
        busy_until = cyc + lat - 1;
        done_at    = cyc + lat;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.irq_req = '0; bus.irq_mask = '1; bus.exl = 1'b0;
    bus.hazard_stall = 1'b0; bus.fifo_full = 1'b0; bus.id_ctrl_xfer = 1'b0;
    bus.id_eret = 1'b0; bus.id_md_mul = 1'b0; bus.id_md_div = 1'b0; bus.id_md_use = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    reset = 1'b0;
    idle_inputs();
    tick(); tick();
    chk("rst_exl_set", 32'(bus.exl_set), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_cause",   32'(bus.irq_cause), 32'd0);
    reset = 1'b1;
    tick();

    // Single enabled line: PEND then TAKE with cause latched.
    bus.irq_req = 6'b000100;
    tick();
    chk("t1_pend_no_take", 32'(bus.exl_set), 32'd0);
    tick();
    chk("t1_take_exl_set",  32'(bus.exl_set),  32'd1);
    chk("t1_take_if_flush", 32'(bus.if_flush), 32'd1);
    chk("t1_cause",         32'(bus.irq_cause), 32'h04);
    bus.irq_req = '0;
    tick();
    chk("t1_one_cycle", 32'(bus.exl_set), 32'd0);
    tick();

    // Control transfer in ID defers the take.
    bus.irq_req = 6'b000001; bus.id_ctrl_xfer = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_deferred", 32'(bus.exl_set), 32'd0);
    end
    bus.id_ctrl_xfer = 1'b0;
    tick();
    chk("t2_take",  32'(bus.exl_set), 32'd1);
    chk("t2_cause", 32'(bus.irq_cause), 32'h01);
    bus.irq_req = '0;
    tick(); tick();

    // Divide occupancy; mfhi/mflo arrives while busy and stalls.
    bus.id_md_div = 1'b1;
    tick();
    bus.id_md_div = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) bus.id_md_use = 1'b1;
      #1;
      if (bus.md_busy) busy_cnt++;
      if (bus.md_done) done_cnt++;
      if (i >= 2 && i < 9) begin
        chk("t3_use_pc_write", 32'(bus.pc_write), 32'd0);
        chk("t3_use_id_flush", 32'(bus.id_flush), 32'd1);
      end
      tick();
    end
    bus.id_md_use = 1'b0;
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("t3_done_pulses", 32'(done_cnt), 32'd1);

    // eret blocked by a full buffer, then released.
    bus.id_eret = 1'b1; bus.fifo_full = 1'b1;
    #1;
    chk("t4_eret_blocked", 32'(bus.exl_clr), 32'd0);
    tick();
    bus.fifo_full = 1'b0;
    #1;
    chk("t4_exl_clr", 32'(bus.exl_clr), 32'd1);
    chk("t4_npc",     32'(bus.npc_from_epc), 32'd1);
    tick();
    bus.id_eret = 1'b0;
    tick();

    // Request withdrawn by masking while held in PEND.
    bus.irq_req = 6'b000010; bus.hazard_stall = 1'b1;
    tick(); tick();
    bus.irq_mask = '0;
    tick(); tick();
    chk("t5_no_take", 32'(bus.exl_set), 32'd0);
    chk("t5_cause_kept", 32'(bus.irq_cause), 32'h01);
    idle_inputs();
    tick();

    // Async reset mid-count and mid-PEND discards both.
    bus.id_md_mul = 1'b1; bus.irq_req = 6'b001000;
    tick();
    bus.id_md_mul = 1'b0;
    chk("t6_counting", 32'(bus.md_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_async_busy",  32'(bus.md_busy),  32'd0);
    chk("t6_async_cause", 32'(bus.irq_cause), 32'd0);
    chk("t6_async_exl",   32'(bus.exl_set),  32'd0);
    tick();
    bus.irq_req = '0;
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.md_done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt), 32'd0);

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 4000; i++) begin
      bus.irq_req      = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
      bus.irq_mask     = ($urandom_range(0, 7) == 0) ? NI'($urandom) : '1;
      bus.exl          = ($urandom_range(0, 9) == 0);
      bus.hazard_stall = ($urandom_range(0, 9) == 0);
      bus.fifo_full    = ($urandom_range(0, 9) == 0);
      bus.id_ctrl_xfer = ($urandom_range(0, 3) == 0);
      bus.id_eret      = ($urandom_range(0, 19) == 0);
      bus.id_md_mul    = ($urandom_range(0, 15) == 0);
      bus.id_md_div    = ($urandom_range(0, 15) == 0);
      bus.id_md_use    = ($urandom_range(0, 7) == 0);
      reset            = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
